edge_freq_counter: RTL and testbench
====================================

// Module: edge_freq_counter
// PURPOSE
//  Gated edge counter that measures a slow, pre-divided signal (e.g. sysclk/N, crypt_clk/N)
//  in the usb_clk domain. Produces the frequency word for the I_sysclk_freq input of the
//  AES/test register block. sig_in is asynchronous and synchronised internally.
//  Count = rising edges per window of 2^pGATE_BITS clk cycles.
// PARAMETERS
//  pGATE_BITS    23  log2 of the gate window length in clk cycles
//  pCNT_WIDTH    32  width of the edge counter and of freq_o
//  pSYNC_STAGES  2   flops in the sig_in synchroniser (>=2)
// PORTS
//  clk         in   1           usb_clk_buf domain clock
//  reset       in   1           synchronous, active-high
//  enable      in   1           run continuous measurements while high
//  clear_i     in   1           one-cycle pulse; clears results, restarts window
//  sig_in      in   1           asynchronous signal to measure (freq < clk/4)
//  freq_o      out  pCNT_WIDTH  last completed edge count
//  valid_o     out  1           freq_o holds a completed measurement
//  overflow_o  out  1           sticky: some window's count saturated
//  update_o    out  1           one-cycle pulse when freq_o is written
//  busy_o      out  1           high in GATE and LATCH
// BEHAVIOUR
//  - Reset: freq_o=0, valid_o=0, overflow_o=0, update_o=0, busy_o=0, state IDLE,
//    synchroniser flops and both counters =0.
//  - Sync chain pSYNC_STAGES deep, plus one edge-detect flop. edge = s & ~s_d.
//    An edge on sig_in is seen by the counter pSYNC_STAGES+1 cycles later.
//    The synchroniser runs in every state, so no false edge appears on entering GATE.
//  - IDLE: counters held at 0. enable=1 -> GATE next cycle.
//  - GATE: lasts exactly 2^pGATE_BITS cycles. gate_cnt counts 0..2^pGATE_BITS-1.
//    edge_cnt increments on every edge in GATE, including the first and last cycles.
//    edge_cnt saturates at all-ones; an edge at all-ones sets the overflow flag for this window.
//    When gate_cnt is at its terminal value -> LATCH.
//  - LATCH (1 cycle): freq_o <= edge_cnt, valid_o <= 1, update_o = 1 this cycle.
//    overflow_o |= window overflow. Counters are cleared.
//    Next state is GATE if enable, else IDLE. An edge in LATCH is not counted (1-cycle dead time).
//  - enable=0 during GATE: abort to IDLE next cycle. Discard counts; freq_o/valid_o/overflow_o keep value.
//  - clear_i (any state): freq_o=0, valid_o=0, overflow_o=0, counters=0.
//    A running measurement restarts in GATE with gate_cnt=0 (or goes to IDLE if enable=0).
//    clear_i wins over a coincident LATCH: no update_o, freq_o=0.
//  - reset wins over clear_i and enable. Reset mid-GATE gives reset values next cycle.
//  - Widths: gate_cnt is pGATE_BITS wide and wraps naturally. edge_cnt is pCNT_WIDTH wide, never wraps.
//  - update_o is never high on two consecutive cycles; minimum spacing is 2^pGATE_BITS+1 cycles.
// TESTING (bench with pGATE_BITS=4, i.e. 16-cycle window)
//  1. enable=1, sig_in period 4 clk -> update_o every 17 cycles; freq_o=4, valid_o=1, overflow_o=0.
//  2. pCNT_WIDTH=3, sig_in period 2 -> freq_o=7 (saturated), overflow_o=1, stays 1 after
//     sig_in slows to period 8 (freq_o=2).
//  3. After a valid result of 4: enable=0 at gate cycle 8 -> no update_o, busy_o=0 after 1 cycle, freq_o stays 4.
//  4. clear_i on the LATCH cycle -> update_o=0, freq_o=0, valid_o=0; next update_o 17 cycles later with freq_o=4.
//  5. reset asserted mid-GATE with sig_in toggling -> next cycle all outputs 0, IDLE;
//     first result after release matches the period.
//  6. sig_in constant 1 or 0, enable=1 -> freq_o=0, valid_o=1, update_o every 17 cycles.

Source files
------------

// File: rtl/edge_freq_counter.sv
// Gated rising-edge counter: counts edges of an asynchronous slow signal over a
// 2^pGATE_BITS-cycle window in the clk domain and publishes the last completed count.
module edge_freq_counter #(
   parameter int unsigned pGATE_BITS   = 23,
   parameter int unsigned pCNT_WIDTH   = 32,
   parameter int unsigned pSYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  clear_i,
   input  logic                  sig_in,
   output logic [pCNT_WIDTH-1:0] freq_o,
   output logic                  valid_o,
   output logic                  overflow_o,
   output logic                  update_o,
   output logic                  busy_o
);

   localparam int unsigned SYNC_MSB = pSYNC_STAGES - 1;
   localparam logic [pGATE_BITS-1:0] GATE_LAST = '1;
   localparam logic [pCNT_WIDTH-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GATE  = 2'd1,
      LATCH = 2'd2
   } state_t;

   state_t                  state, state_nxt;
   logic [pSYNC_STAGES-1:0] sync_q;
   logic                    sync_d;
   logic                    edge_c;
   logic [pGATE_BITS-1:0]   gate_cnt, gate_cnt_nxt;
   logic [pCNT_WIDTH-1:0]   edge_cnt, edge_cnt_nxt;
   logic                    win_ovf, win_ovf_nxt;
   logic [pCNT_WIDTH-1:0]   freq_nxt;
   logic                    valid_nxt, ovf_nxt, update_nxt, busy_nxt;

   // Synchroniser and edge-detect flop run in every state so entering GATE never sees a false edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         sync_d <= 1'b0;
      end else begin
         sync_q <= {sync_q[pSYNC_STAGES-2:0], sig_in};
         sync_d <= sync_q[SYNC_MSB];
      end
   end

   assign edge_c = sync_q[SYNC_MSB] & ~sync_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         gate_cnt   <= '0;
         edge_cnt   <= '0;
         win_ovf    <= 1'b0;
         freq_o     <= '0;
         valid_o    <= 1'b0;
         overflow_o <= 1'b0;
         update_o   <= 1'b0;
         busy_o     <= 1'b0;
      end else begin
         state      <= state_nxt;
         gate_cnt   <= gate_cnt_nxt;
         edge_cnt   <= edge_cnt_nxt;
         win_ovf    <= win_ovf_nxt;
         freq_o     <= freq_nxt;
         valid_o    <= valid_nxt;
         overflow_o <= ovf_nxt;
         update_o   <= update_nxt;
         busy_o     <= busy_nxt;
      end
   end

   // Next state, counters and result registers; clear_i overrides everything below it.
   always_comb begin
      state_nxt    = state;
      gate_cnt_nxt = gate_cnt;
      edge_cnt_nxt = edge_cnt;
      win_ovf_nxt  = win_ovf;
      freq_nxt     = freq_o;
      valid_nxt    = valid_o;
      ovf_nxt      = overflow_o;
      update_nxt   = 1'b0;

      unique case (state)
         IDLE: begin
            gate_cnt_nxt = '0;
            edge_cnt_nxt = '0;
            win_ovf_nxt  = 1'b0;
            if (enable) state_nxt = GATE;
         end
         GATE: begin
            if (!enable) begin
               state_nxt    = IDLE;
               gate_cnt_nxt = '0;
               edge_cnt_nxt = '0;
               win_ovf_nxt  = 1'b0;
            end else begin
               gate_cnt_nxt = gate_cnt + pGATE_BITS'(1);
               if (edge_c) begin
                  if (edge_cnt == CNT_MAX) win_ovf_nxt = 1'b1;
                  else edge_cnt_nxt = edge_cnt + pCNT_WIDTH'(1);
               end
               if (gate_cnt == GATE_LAST) state_nxt = LATCH;
            end
         end
         LATCH: begin
            freq_nxt     = edge_cnt;
            valid_nxt    = 1'b1;
            update_nxt   = 1'b1;
            ovf_nxt      = overflow_o | win_ovf;
            gate_cnt_nxt = '0;
            edge_cnt_nxt = '0;
            win_ovf_nxt  = 1'b0;
            state_nxt    = enable ? GATE : IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      if (clear_i) begin
         freq_nxt     = '0;
         valid_nxt    = 1'b0;
         ovf_nxt      = 1'b0;
         update_nxt   = 1'b0;
         gate_cnt_nxt = '0;
         edge_cnt_nxt = '0;
         win_ovf_nxt  = 1'b0;
         state_nxt    = enable ? GATE : IDLE;
      end

      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_edge_freq_counter.sv
// Self-checking bench for edge_freq_counter with a 16-cycle gate window;
// expected counts come from the recorded sig_in samples and the window timing.
`timescale 1ns/1ps
module tb_edge_freq_counter;

   localparam int GB   = 4;
   localparam int SS   = 2;
   localparam int WIN  = 1 << GB;
   localparam int PER  = WIN + 1;
   localparam int MAXC = 8192;

   logic        clk = 1'b0;
   logic        reset, enable, clear_i, sig_in;
   logic [31:0] freq;
   logic        valid, ovf, upd, busy;
   logic [2:0]  freq_s;
   logic        valid_s, ovf_s, upd_s, busy_s;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic samp [0:MAXC-1];
   int   sig_mode = 1;
   int   half = 2;
   int   ph = 0;
   logic sig_level = 1'b0;

   always #5 clk = ~clk;

   edge_freq_counter #(.pGATE_BITS(GB), .pCNT_WIDTH(32), .pSYNC_STAGES(SS)) dut (
      .clk(clk), .reset(reset), .enable(enable), .clear_i(clear_i), .sig_in(sig_in),
      .freq_o(freq), .valid_o(valid), .overflow_o(ovf), .update_o(upd), .busy_o(busy));

   edge_freq_counter #(.pGATE_BITS(GB), .pCNT_WIDTH(3), .pSYNC_STAGES(SS)) dut_sat (
      .clk(clk), .reset(reset), .enable(enable), .clear_i(clear_i), .sig_in(sig_in),
      .freq_o(freq_s), .valid_o(valid_s), .overflow_o(ovf_s), .update_o(upd_s), .busy_o(busy_s));

   // One clock: record sig_in as the DUT samples it, then update the signal generator.
   task automatic tick();
      @(posedge clk);
      if (cyc < MAXC) samp[cyc] = sig_in;
      cyc++;
      @(negedge clk);
      if (sig_mode == 0) sig_in = sig_level;
      else if (ph <= 1) begin
         sig_in = ~sig_in;
         ph = (sig_mode == 2) ? int'($urandom_range(6, 2)) : half;
      end else ph--;
   endtask

   // Rising edges of the sampled input whose synchronised arrival lands on posedges first_p..last_p.
   function automatic int raw_count(input int first_p, input int last_p);
      int n = 0;
      for (int p = first_p; p <= last_p; p++)
         if (samp[p-SS] === 1'b1 && samp[p-SS-1] === 1'b0) n++;
      return n;
   endfunction

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; clear_i = 1'b0; sig_in = 1'b0;
      sig_mode = 1; half = 2;
      repeat (3) tick();
      checks++; if (freq !== 32'd0) begin errors++; $display("FAIL reset_freq: got %0d want 0", freq); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
      checks++; if (upd !== 1'b0) begin errors++; $display("FAIL reset_upd: got %b want 0", upd); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if ({freq_s, valid_s, ovf_s, upd_s, busy_s} !== 7'd0) begin
         errors++; $display("FAIL reset_sat: got %b want 0", {freq_s, valid_s, ovf_s, upd_s, busy_s}); end
      reset = 1'b0;
   endtask

   // Continuous measurement; mode 1 = period 4, mode 2 = random half periods 2..6.
   task automatic test_period(input int mode, input int windows);
      int e, p, raw;
      logic exp_upd;
      sig_mode = mode; half = 2;
      repeat (4) tick();
      enable = 1'b1; e = cyc;
      for (int k = 0; k <= windows*PER; k++) begin
         tick(); p = cyc - 1;
         exp_upd = (p > e) && ((p - e) % PER == 0);
         checks++; if (upd !== exp_upd) begin errors++; $display("FAIL period_upd p=%0d: got %b want %b", p - e, upd, exp_upd); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL period_busy p=%0d: got %b want 1", p - e, busy); end
         checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL period_ovf p=%0d: got %b want 0", p - e, ovf); end
         if (exp_upd) begin
            raw = raw_count(p - WIN, p - 1);
            checks++; if (freq !== 32'(raw)) begin errors++; $display("FAIL period_freq p=%0d: got %0d want %0d", p - e, freq, raw); end
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL period_valid: got %b want 1", valid); end
            if (mode == 1) begin
               checks++; if (freq !== 32'd4) begin errors++; $display("FAIL period4_freq: got %0d want 4", freq); end
            end
         end
      end
      enable = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_saturate();
      int e, p, raw, sat;
      logic exp_upd, sticky;
      clear_i = 1'b1; tick(); clear_i = 1'b0;
      checks++; if ({freq_s, valid_s, ovf_s} !== 5'd0) begin errors++; $display("FAIL sat_clear: got %b want 0", {freq_s, valid_s, ovf_s}); end
      sig_mode = 1; half = 1;
      repeat (4) tick();
      enable = 1'b1; e = cyc; sticky = 1'b0; sat = 0;
      for (int k = 0; k <= 4*PER; k++) begin
         if (k == 2*PER + 1) half = 4;
         tick(); p = cyc - 1;
         exp_upd = (p > e) && ((p - e) % PER == 0);
         checks++; if (upd_s !== exp_upd) begin errors++; $display("FAIL sat_upd p=%0d: got %b want %b", p - e, upd_s, exp_upd); end
         if (exp_upd) begin
            raw = raw_count(p - WIN, p - 1);
            sat = (raw > 7) ? 7 : raw;
            sticky = sticky | (raw > 7);
            checks++; if (freq_s !== 3'(sat)) begin errors++; $display("FAIL sat_freq p=%0d: got %0d want %0d", p - e, freq_s, sat); end
         end
         checks++; if (ovf_s !== sticky) begin errors++; $display("FAIL sat_ovf p=%0d: got %b want %b", p - e, ovf_s, sticky); end
      end
      checks++; if (freq_s !== 3'd2) begin errors++; $display("FAIL sat_slow_final: got %0d want 2", freq_s); end
      checks++; if (ovf_s !== 1'b1) begin errors++; $display("FAIL sat_sticky_final: got %b want 1", ovf_s); end
      enable = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_abort();
      int e, p, held;
      sig_mode = 1; half = 2;
      repeat (4) tick();
      enable = 1'b1; e = cyc;
      repeat (PER + 1) tick();
      p = cyc - 1; held = raw_count(p - WIN, p - 1);
      checks++; if (upd !== 1'b1) begin errors++; $display("FAIL abort_first_upd: got %b want 1", upd); end
      checks++; if (freq !== 32'(held)) begin errors++; $display("FAIL abort_first_freq: got %0d want %0d", freq, held); end
      repeat (8) tick();
      enable = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
      for (int k = 0; k < 2*PER; k++) begin
         checks++; if (upd !== 1'b0) begin errors++; $display("FAIL abort_upd k=%0d: got %b want 0", k, upd); end
         checks++; if (freq !== 32'(held) || valid !== 1'b1) begin
            errors++; $display("FAIL abort_hold k=%0d: got %0d/%b want %0d/1", k, freq, valid, held); end
         tick();
      end
   endtask

   task automatic test_clear_latch();
      int e, p, raw;
      logic exp_upd;
      sig_mode = 1; half = 2;
      repeat (4) tick();
      enable = 1'b1; e = cyc;
      repeat (WIN + 1) tick();
      clear_i = 1'b1; tick(); clear_i = 1'b0;
      checks++; if (upd !== 1'b0) begin errors++; $display("FAIL clr_upd: got %b want 0", upd); end
      checks++; if (freq !== 32'd0 || valid !== 1'b0 || ovf !== 1'b0) begin
         errors++; $display("FAIL clr_outputs: got %0d/%b/%b want 0/0/0", freq, valid, ovf); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy: got %b want 1", busy); end
      e = cyc - 1;
      for (int k = 0; k < PER; k++) begin
         tick(); p = cyc - 1;
         exp_upd = (p == e + PER);
         checks++; if (upd !== exp_upd) begin errors++; $display("FAIL clr_next_upd p=%0d: got %b want %b", p - e, upd, exp_upd); end
         if (exp_upd) begin
            raw = raw_count(p - WIN, p - 1);
            checks++; if (freq !== 32'(raw) || freq !== 32'd4) begin errors++; $display("FAIL clr_next_freq: got %0d want %0d", freq, raw); end
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL clr_next_valid: got %b want 1", valid); end
         end
      end
      enable = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_reset_mid();
      int e, p, raw;
      logic exp_upd;
      sig_mode = 2;
      enable = 1'b1;
      repeat (PER + 9) tick();
      reset = 1'b1; clear_i = 1'b1; tick(); clear_i = 1'b0;
      checks++; if ({freq, valid, ovf, upd, busy} !== 36'd0) begin
         errors++; $display("FAIL rstmid_outputs: got %h want 0", {freq, valid, ovf, upd, busy}); end
      checks++; if ({freq_s, valid_s, ovf_s, upd_s, busy_s} !== 7'd0) begin
         errors++; $display("FAIL rstmid_sat: got %b want 0", {freq_s, valid_s, ovf_s, upd_s, busy_s}); end
      enable = 1'b0; tick(); reset = 1'b0;
      repeat (4) tick();
      enable = 1'b1; e = cyc;
      for (int k = 0; k <= 3*PER; k++) begin
         tick(); p = cyc - 1;
         exp_upd = (p > e) && ((p - e) % PER == 0);
         checks++; if (upd !== exp_upd) begin errors++; $display("FAIL rstmid_upd p=%0d: got %b want %b", p - e, upd, exp_upd); end
         if (exp_upd) begin
            raw = raw_count(p - WIN, p - 1);
            checks++; if (freq !== 32'(raw) || valid !== 1'b1) begin
               errors++; $display("FAIL rstmid_freq p=%0d: got %0d/%b want %0d/1", p - e, freq, valid, raw); end
         end
      end
      enable = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_constant();
      int e, p;
      logic exp_upd;
      for (int lvl = 1; lvl >= 0; lvl--) begin
         sig_mode = 0; sig_level = 1'(lvl);
         repeat (4) tick();
         enable = 1'b1; e = cyc;
         for (int k = 0; k <= 2*PER; k++) begin
            tick(); p = cyc - 1;
            exp_upd = (p > e) && ((p - e) % PER == 0);
            checks++; if (upd !== exp_upd) begin errors++; $display("FAIL const%0d_upd p=%0d: got %b want %b", lvl, p - e, upd, exp_upd); end
            if (exp_upd) begin
               checks++; if (freq !== 32'd0 || valid !== 1'b1) begin
                  errors++; $display("FAIL const%0d_freq: got %0d/%b want 0/1", lvl, freq, valid); end
            end
         end
         enable = 1'b0;
         repeat (2) tick();
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; clear_i = 1'b0; sig_in = 1'b0;
      test_reset();
      test_period(1, 3);
      test_period(2, 4);
      test_saturate();
      test_abort();
      test_clear_latch();
      test_reset_mid();
      test_constant();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
